// File: rtl/norm1_udiv_31ns_6ns_25_seq.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, with
// valid/ready handshakes on both sides and saturated quotient / flag outputs.
module norm1_udiv_31ns_6ns_25_seq #(
    parameter int unsigned din0_WIDTH = 31,
    parameter int unsigned din1_WIDTH = 6,
    parameter int unsigned dout_WIDTH = 25
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_zero,
    output logic                  ovf
);

    localparam int unsigned REM_W = din1_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(din0_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [din0_WIDTH-1:0]   dvd_q;
    logic [din0_WIDTH-1:0]   q_q;
    logic [din1_WIDTH-1:0]   dvs_q;
    logic [REM_W-1:0]        rem_q;
    logic [CNT_W-1:0]        cnt_q;

    logic                    accept_c;
    logic                    step_ge_c;
    logic                    q_ovf_c;
    logic [REM_W-1:0]        dvs_ext_c;
    logic [REM_W-1:0]        rem_shift_c;
    logic [REM_W-1:0]        rem_next_c;

    assign accept_c    = in_valid && in_ready;
    assign dvs_ext_c   = {1'b0, dvs_q};
    // Extra remainder bit keeps the shifted value from wrapping before the compare.
    assign rem_shift_c = (rem_q << 1) | REM_W'(dvd_q[din0_WIDTH-1]);
    assign step_ge_c   = rem_shift_c >= dvs_ext_c;
    assign rem_next_c  = step_ge_c ? (rem_shift_c - dvs_ext_c) : rem_shift_c;
    assign q_ovf_c     = (q_q >> dout_WIDTH) != '0;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            q_q       <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quot      <= '0;
            rem       <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        dvd_q <= din0;
                        dvs_q <= din1;
                        q_q   <= '0;
                        rem_q <= '0;
                        cnt_q <= CNT_W'(din0_WIDTH);
                    end
                end
                CALC: begin
                    if (cnt_q != '0) begin
                        dvd_q <= dvd_q << 1;
                        rem_q <= rem_next_c;
                        q_q   <= {q_q[din0_WIDTH-2:0], step_ge_c};
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (dvs_q == '0) begin
                        quot     <= '1;
                        rem      <= '0;
                        div_zero <= 1'b1;
                        ovf      <= 1'b0;
                    end else if (q_ovf_c) begin
                        quot     <= '1;
                        rem      <= din1_WIDTH'(rem_q);
                        div_zero <= 1'b0;
                        ovf      <= 1'b1;
                    end else begin
                        quot     <= dout_WIDTH'(q_q);
                        rem      <= din1_WIDTH'(rem_q);
                        div_zero <= 1'b0;
                        ovf      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_norm1_udiv_31ns_6ns_25_seq.sv
// Scoreboard bench for the sequential divider: driver pushes expected results,
// monitor pops and compares whenever a result is presented.
module tb_norm1_udiv_31ns_6ns_25_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [30:0] din0 = '0;
    logic [5:0]  din1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [24:0] quot;
    logic [5:0]  rem;
    logic        div_zero;
    logic        ovf;

    norm1_udiv_31ns_6ns_25_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din0     (din0),
        .din1     (din1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [24:0] q;
        logic [5:0]  r;
        logic        dz;
        logic        ov;
        longint      t_acc;
        int          hold;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    longint t_rel = 0;
    int     seen = 0;
    int     hold = 0;
    int     rel_pending = 0;
    logic [32:0] snap = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer division with the saturation rules.
    function automatic exp_t model(input logic [30:0] a, input logic [5:0] b, input int h);
        exp_t e;
        longint unsigned aa, bb, qq;
        aa = 64'(a);
        bb = 64'(b);
        e.t_acc = 0;
        e.hold  = h;
        if (bb == 0) begin
            e.q = '1; e.r = '0; e.dz = 1'b1; e.ov = 1'b0;
        end else begin
            qq   = aa / bb;
            e.r  = 6'(aa % bb);
            e.dz = 1'b0;
            if (qq >= 64'd33554432) begin
                e.q = '1; e.ov = 1'b1;
            end else begin
                e.q = 25'(qq); e.ov = 1'b0;
            end
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [24:0] q, input logic [5:0] r,
                                input logic dz, input logic ov, input int h);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.t_acc = 0; e.hold = h;
        return e;
    endfunction

    task automatic send(input logic [30:0] a, input logic [5:0] b, input exp_t e, output longint tacc);
        int n = 0;
        exp_t x = e;
        tacc = 0;
        din0 = a;
        din1 = b;
        in_valid = 1'b1;
        while (!in_ready) begin
            @(negedge ap_clk);
            n++;
            if (n > 500) begin
                chk("accept_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge ap_clk);
        tacc = $time;
        x.t_acc = tacc;
        sb.push_back(x);
        #1;
        in_valid = 1'b0;
        din0 = 31'($urandom);
        din1 = 6'($urandom);
    endtask

    // Monitor: compare on first presentation, then check stability under backpressure.
    always @(negedge ap_clk) begin
        exp_t cur;
        if (!ap_rst_n) begin
            seen = 0; hold = 0; rel_pending = 0;
        end else begin
            if (rel_pending != 0) begin
                rel_pending = 0;
                chk("valid_drop", 64'(out_valid), 64'd0);
                chk("ready_after_done", 64'(in_ready), 64'd1);
            end
            if (out_valid) begin
                if (seen == 0) begin
                    seen = 1;
                    snap = {quot, rem, div_zero, ovf};
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 64'(out_valid), 64'd0);
                        hold = 0;
                    end else begin
                        cur = sb.pop_front();
                        chk("latency", 64'($time - cur.t_acc), 64'd325);
                        chk("quot", 64'(quot), 64'(cur.q));
                        chk("rem", 64'(rem), 64'(cur.r));
                        chk("div_zero", 64'(div_zero), 64'(cur.dz));
                        chk("ovf", 64'(ovf), 64'(cur.ov));
                        hold = cur.hold;
                    end
                end else begin
                    chk("hold_stable", 64'({quot, rem, div_zero, ovf}), 64'(snap));
                    chk("in_ready_busy", 64'(in_ready), 64'd0);
                end
                if (hold > 0) begin
                    hold--;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    rel_pending = 1;
                    t_rel = $time + 5;
                end
            end else begin
                seen = 0;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        longint ta;
        longint tb2;
        logic [30:0] a;
        logic [5:0]  b;
        int n;

        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_outputs", 64'({out_valid, quot, rem, div_zero, ovf}), 64'd0);
        @(negedge ap_clk) ap_rst_n = 1'b1;
        @(posedge ap_clk) #1;
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        send(31'd1000, 6'd7, mk(25'd142, 6'd6, 1'b0, 1'b0, 0), ta);
        send(31'd2113929153, 6'd63, mk(25'h1FFFFFF, 6'd0, 1'b0, 1'b0, 0), ta);
        send(31'h7FFFFFFF, 6'd1, mk(25'h1FFFFFF, 6'd0, 1'b0, 1'b1, 0), ta);
        send(31'h7FFFFFFF, 6'd3, mk(25'h1FFFFFF, 6'd1, 1'b0, 1'b1, 0), ta);
        send(31'd5, 6'd0, mk(25'h1FFFFFF, 6'd0, 1'b1, 1'b0, 0), ta);
        send(31'd0, 6'd13, mk(25'd0, 6'd0, 1'b0, 1'b0, 0), ta);

        // Backpressure for 10 cycles, then the next operand follows one cycle after release.
        send(31'd1000, 6'd7, mk(25'd142, 6'd6, 1'b0, 1'b0, 10), ta);
        send(31'd77777, 6'd5, model(31'd77777, 6'd5, 0), tb2);
        chk("accept_after_release", 64'(tb2 - t_rel), 64'd10);

        // Reset in the middle of a division: nothing may emerge from it.
        send(31'd12345, 6'd7, model(31'd12345, 6'd7, 0), ta);
        repeat (15) @(posedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 64'({out_valid, quot, rem, div_zero, ovf}), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        @(negedge ap_clk) ap_rst_n = 1'b1;
        @(posedge ap_clk) #1;
        chk("ready_after_midrst", 64'(in_ready), 64'd1);
        send(31'd100, 6'd9, mk(25'd11, 6'd1, 1'b0, 1'b0, 0), ta);

        for (int i = 0; i < 150; i++) begin
            a = (($urandom % 3) == 0) ? 31'($urandom_range(0, 5000)) : 31'($urandom);
            b = (($urandom % 8) == 0) ? 6'd0 : 6'($urandom);
            send(a, b, model(a, b, int'($urandom_range(0, 3))), ta);
        end

        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 2000) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 2000) chk("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge ap_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
